fetch_stage: RTL and testbench

Instruction fetch stage of the five-stage pipeline: owns the fetch program counter, issues requests to instruction memory over a req/ack handshake, buffers returned words in a 2-entry prefetch FIFO, and drives the fetch→decode pipeline register. It consumes `stall_F`, `flush_D` and `jumping` from the hazard logic and the redirect target from execute. Its outputs feed the decode stage directly.

---
 rtl/fetch_stage.sv | 145 ++++++++++++++
 tb/tb_fetch_stage.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the fetch PC, runs the imem req/ack
// handshake, buffers returned words in a 2-entry prefetch FIFO and drives
// the fetch->decode pipeline register.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_F,
  input  logic        flush_D,
  input  logic        jumping,
  input  logic [31:0] jump_addr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_data,
  output logic [31:0] instr_D,
  output logic [31:0] pc_D,
  output logic        valid_D
);

  typedef enum logic {FETCH, DRAIN} state_e;

  state_e      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;

  logic [31:0] fifo_pc_q    [2];
  logic [31:0] fifo_instr_q [2];
  logic        rd_ptr_q, wr_ptr_q;
  logic [1:0]  count_q;

  logic [31:0] target;
  logic        xfer, push, push_eff, pop, clear;

  logic [31:0] instr_q, pc_q;
  logic        valid_q;

  assign target = jump_addr & ~32'd3;

  // Bus request: an open request is never withdrawn except by reset.
  always_comb begin
    imem_req  = !reset && (state_q == DRAIN || count_q != 2'd2);
    imem_addr = fetch_pc_q;
    xfer      = imem_req && imem_ack;
  end

  // Fetch PC / redirect bookkeeping; a pending request must complete at
  // its old address, so a redirect during it parks the target in DRAIN.
  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    redirect_pc_d = redirect_pc_q;
    push          = 1'b0;
    case (state_q)
      FETCH: begin
        if (jumping) begin
          if (imem_req && !imem_ack) begin
            redirect_pc_d = target;
            state_d       = DRAIN;
          end else begin
            fetch_pc_d = target;
          end
        end else if (xfer) begin
          push       = 1'b1;
          fetch_pc_d = fetch_pc_q + 32'd4;
        end
      end
      DRAIN: begin
        if (imem_ack) begin
          fetch_pc_d = jumping ? target : redirect_pc_q;
          state_d    = FETCH;
        end else if (jumping) begin
          redirect_pc_d = target;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  // Decode-side FIFO control: a flush or redirect wins over everything,
  // including a push landing in the same cycle.
  always_comb begin
    clear    = flush_D || jumping;
    push_eff = push && !clear;
    pop      = !clear && !stall_F && (count_q != 2'd0);
  end

  // FSM, PC, FIFO occupancy and decode register state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= FETCH;
      fetch_pc_q    <= RESET_PC;
      redirect_pc_q <= RESET_PC;
      rd_ptr_q      <= 1'b0;
      wr_ptr_q      <= 1'b0;
      count_q       <= '0;
      instr_q       <= NOP_INSTR;
      pc_q          <= '0;
      valid_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      redirect_pc_q <= redirect_pc_d;
      if (clear) begin
        rd_ptr_q <= 1'b0;
        wr_ptr_q <= 1'b0;
        count_q  <= '0;
      end else begin
        if (push_eff) wr_ptr_q <= ~wr_ptr_q;
        if (pop)      rd_ptr_q <= ~rd_ptr_q;
        count_q <= count_q + {1'b0, push_eff} - {1'b0, pop};
      end
      if (clear) begin
        instr_q <= NOP_INSTR;
        valid_q <= 1'b0;
      end else if (stall_F) begin
        instr_q <= instr_q;
        pc_q    <= pc_q;
        valid_q <= valid_q;
      end else if (count_q != 2'd0) begin
        instr_q <= fifo_instr_q[rd_ptr_q];
        pc_q    <= fifo_pc_q[rd_ptr_q];
        valid_q <= 1'b1;
      end else begin
        instr_q <= NOP_INSTR;
        valid_q <= 1'b0;
      end
    end
  end

  // FIFO storage; contents are only meaningful below count_q.
  always_ff @(posedge clk) begin
    if (!reset && push_eff) begin
      fifo_pc_q[wr_ptr_q]    <= fetch_pc_q;
      fifo_instr_q[wr_ptr_q] <= imem_data;
    end
  end

  assign instr_D = instr_q;
  assign pc_D    = pc_q;
  assign valid_D = valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized scoreboard bench for fetch_stage with a queue-based reference
// model of the fetch pipeline and a memory returning addr+0x100.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset, stall_F, flush_D, jumping, imem_ack;
  logic [31:0] jump_addr, imem_data, imem_addr, instr_D, pc_D;
  logic        imem_req, valid_D;

  always #5 clk = ~clk;

  assign imem_data = imem_addr + 32'h100;

  fetch_stage #(.RESET_PC(32'h0000_0000), .NOP_INSTR(NOP)) dut (
    .clk(clk), .reset(reset), .stall_F(stall_F), .flush_D(flush_D),
    .jumping(jumping), .jump_addr(jump_addr), .imem_req(imem_req),
    .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
    .instr_D(instr_D), .pc_D(pc_D), .valid_D(valid_D)
  );

  typedef struct {
    bit          chk;
    logic        req;
    logic [31:0] addr;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        valid;
  } exp_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } word_t;

  exp_t  sb[$];
  word_t mq[$];

  bit          m_known = 0, m_drain = 0, m_valid = 0;
  logic [31:0] m_pc = '0, m_redir = '0, m_instr = NOP, m_pcD = '0;
  int unsigned cnt = 0, lat = 0;
  bit          rand_lat = 0;
  int          vectors = 0, miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Monitor: every cycle the DUT presents req/addr and decode outputs.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("imem_req", {31'b0, imem_req}, {31'b0, e.req});
        if (e.chk) begin
          chk("imem_addr", imem_addr, e.addr);
          chk("instr_D", instr_D, e.instr);
          chk("pc_D", pc_D, e.pc);
          chk("valid_D", {31'b0, valid_D}, {31'b0, e.valid});
        end
      end
    end
  end

  // One clock of stimulus plus reference-model step.
  task automatic cycle(input bit rst, input bit st, input bit fl, input bit jp,
                       input logic [31:0] tgt);
    exp_t  e;
    word_t w;
    bit    req, ack, xfer, push;
    logic [31:0] t;
    t    = tgt & 32'hFFFF_FFFC;
    req  = !rst && (m_drain || mq.size() < 2);
    ack  = req ? (cnt >= lat) : ($urandom_range(0, 1) == 1);
    reset = rst; stall_F = st; flush_D = fl; jumping = jp;
    jump_addr = tgt; imem_ack = ack;
    e.chk = m_known; e.req = req; e.addr = m_pc;
    e.instr = m_instr; e.pc = m_pcD; e.valid = m_valid;
    sb.push_back(e);
    if (rst) begin
      m_known = 1; m_pc = '0; m_drain = 0; mq.delete();
      m_instr = NOP; m_pcD = '0; m_valid = 0; cnt = 0;
    end else begin
      xfer = req && ack;
      push = 0;
      w.pc = m_pc; w.instr = m_pc + 32'h100;
      if (!m_drain) begin
        if (jp) begin
          if (req && !ack) begin m_redir = t; m_drain = 1; end
          else m_pc = t;
        end else if (xfer) begin
          push = 1; m_pc = m_pc + 32'd4;
        end
      end else begin
        if (ack) begin m_pc = jp ? t : m_redir; m_drain = 0; end
        else if (jp) m_redir = t;
      end
      if (fl || jp) begin
        m_instr = NOP; m_valid = 0; mq.delete();
      end else if (st) begin
        if (push) mq.push_back(w);
      end else if (mq.size() > 0) begin
        m_instr = mq[0].instr; m_pcD = mq[0].pc; m_valid = 1;
        void'(mq.pop_front());
        if (push) mq.push_back(w);
      end else begin
        m_instr = NOP; m_valid = 0;
        if (push) mq.push_back(w);
      end
      if (xfer) begin
        cnt = 0;
        if (rand_lat) lat = $urandom_range(0, 3);
      end else if (req) cnt++;
    end
    @(posedge clk); #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, '0);
  endtask

  // Advance until the model has a fresh FETCH request one cycle old.
  task automatic wait_pending();
    for (int i = 0; i < 20 && !(!m_drain && mq.size() < 2 && cnt == 1); i++)
      cycle(0, 0, 0, 0, '0);
  endtask

  initial begin
    reset = 1; stall_F = 0; flush_D = 0; jumping = 0; jump_addr = '0; imem_ack = 0;
    @(posedge clk); #1;
    cycle(1, 0, 0, 0, '0);
    cycle(1, 0, 0, 0, '0);
    // Zero-wait streaming.
    lat = 0;
    run(10);
    // Stall mid-stream for 4 cycles.
    for (int i = 0; i < 4; i++) cycle(0, 1, 0, 0, '0);
    run(6);
    // Redirect with slow memory: stale request drains, then 0x200.
    lat = 3;
    wait_pending();
    cycle(0, 0, 0, 1, 32'h203);
    run(10);
    // Two redirects within one drain: latest target wins.
    wait_pending();
    cycle(0, 0, 0, 1, 32'h400);
    cycle(0, 0, 0, 1, 32'h800);
    run(10);
    // Redirect coincident with a zero-wait ack.
    lat = 0;
    run(3);
    cycle(0, 0, 0, 1, 32'h300);
    run(5);
    // Address wrap at the top of the space.
    cycle(0, 0, 0, 1, 32'hFFFF_FFFE);
    run(5);
    // Flush alone.
    cycle(0, 0, 1, 0, '0);
    run(4);
    // Fill FIFO under stall, then reset.
    for (int i = 0; i < 3; i++) cycle(0, 1, 0, 0, '0);
    cycle(1, 1, 0, 0, '0);
    run(5);
    // Reset while a slow request is pending.
    lat = 3;
    wait_pending();
    cycle(1, 0, 0, 0, '0);
    run(8);
    // Randomized traffic.
    rand_lat = 1;
    for (int i = 0; i < 400; i++) begin
      bit st, fl, jp, rs;
      logic [31:0] tg;
      rs = ($urandom_range(0, 99) < 1);
      st = ($urandom_range(0, 99) < 25);
      fl = ($urandom_range(0, 99) < 5);
      jp = ($urandom_range(0, 99) < 6);
      tg = ($urandom_range(0, 9) == 0) ? (32'hFFFF_FFF0 | $urandom_range(0, 15))
                                       : ($urandom & 32'h0000_FFFF);
      cycle(rs, st, fl, jp, tg);
    end
    run(6);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
